stencil_out_stream: RTL and testbench

//  Reader end of the stencil pipeline's output port: takes one kernel result per accepted beat
//  (e.g. cu_output's out_output_write_0) and turns it into a valid/ready stream.

---
 rtl/stencil_stream_pkg.sv | 25 ++
 rtl/stencil_out_fifo.sv | 75 +++++++
 rtl/stencil_out_stream.sv | 130 +++++++++++++
 tb/tb_stencil_out_stream.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stencil_stream_pkg.sv
// -----------------------------------------------------------------------------
// stencil_stream_pkg
// Shared types and default geometry for the stencil output stream.
//   stencil_beat_t : one buffered output beat {data, eol, last}
//   COL_W / ROW_W  : raster counter widths for the default image size
// -----------------------------------------------------------------------------
package stencil_stream_pkg;

    localparam int BEAT_WIDTH     = 16;
    localparam int DEF_IMG_W      = 64;
    localparam int DEF_IMG_H      = 64;
    localparam int DEF_COL_MIN    = 4;
    localparam int DEF_ROW_MIN    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int COL_W = $clog2(DEF_IMG_W);
    localparam int ROW_W = $clog2(DEF_IMG_H);

    typedef struct packed {
        logic [BEAT_WIDTH-1:0] data;
        logic                  eol;
        logic                  last;
    } stencil_beat_t;

endpackage

// File: rtl/stencil_out_fifo.sv
// -----------------------------------------------------------------------------
// stencil_out_fifo
// Small synchronous first-word-fall-through FIFO of stencil_beat_t.
// A beat written in cycle t is visible on head in cycle t+1.
// Ports:
//   clk, srst  : clock, synchronous active-high reset
//   push, beat : write beat when push && !full
//   pop        : discard head when pop && count != 0
//   head       : current head beat, all-zero when empty
//   full       : count == DEPTH
//   count      : occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module stencil_out_fifo
    import stencil_stream_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  stencil_beat_t            beat,
    input  logic                     pop,
    output stencil_beat_t            head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    stencil_beat_t  mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;

    logic           do_push;
    logic           do_pop;
    logic           empty;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= beat;
        end
    end

    // Pointers are power-of-two wide, so they wrap modulo DEPTH by overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head = empty ? stencil_beat_t'('0) : mem[rd_ptr_reg];

endmodule

// File: rtl/stencil_out_stream.sv
// -----------------------------------------------------------------------------
// stencil_out_stream
// Reader end of the stencil pipeline: accepts one kernel result per beat,
// tracks raster position, drops warm-up / edge-straddling windows and emits
// the kept pixels as a valid/ready stream tagged with end-of-line and
// end-of-frame. Downstream backpressure turns into an upstream stall only
// for beats that would be kept.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_data   : upstream result, accepted when in_valid && in_ready
//   in_ready            : low only when the FIFO is full and this beat is kept
//   out_valid, out_data : head-of-FIFO beat (data forced 0 when empty)
//   out_eol, out_last   : head beat ends its row / ends the frame
//   out_ready           : downstream takes head when out_valid && out_ready
//   stall_cycles        : only with STENCIL_OUT_PERF_EN defined; saturating
//                         count of cycles with in_valid && !in_ready
// WIDTH must equal the package BEAT_WIDTH since the beat struct is shared.
// -----------------------------------------------------------------------------
module stencil_out_stream
    import stencil_stream_pkg::*;
#(
    parameter int WIDTH      = BEAT_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int COL_MIN    = DEF_COL_MIN,
    parameter int ROW_MIN    = DEF_ROW_MIN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_eol,
    output logic             out_last,
    input  logic             out_ready
`ifdef STENCIL_OUT_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]  col_reg;
    logic [RW-1:0]  row_reg;

    logic           keep;
    logic           col_last;
    logic           row_last;
    logic           accept;
    logic           push;
    logic           pop;

    stencil_beat_t  push_beat;
    stencil_beat_t  head_beat;
    logic           fifo_full;
    logic [FW-1:0]  fifo_count;

    // Keep decision comes from the position of the next beat to be accepted,
    // independent of in_valid, so in_ready is stable ahead of the beat.
    assign keep     = (col_reg >= CW'(COL_MIN)) && (row_reg >= RW'(ROW_MIN));
    assign col_last = (col_reg == CW'(IMG_W - 1));
    assign row_last = (row_reg == RW'(IMG_H - 1));

    // Dropped beats never stall; no look-through of a same-cycle pop.
    assign in_ready = !fifo_full || !keep;
    assign accept   = in_valid && in_ready;
    assign push     = accept && keep;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = in_data;
        push_beat.eol  = col_last;
        push_beat.last = col_last && row_last;
    end

    stencil_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (push),
        .beat  (push_beat),
        .pop   (pop),
        .head  (head_beat),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Head is already zeroed by the FIFO when empty.
    assign out_valid = (fifo_count != '0);
    assign out_data  = head_beat.data;
    assign out_eol   = head_beat.eol;
    assign out_last  = head_beat.last;

`ifdef STENCIL_OUT_PERF_EN
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (in_valid && !in_ready && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_stencil_out_stream.sv
// -----------------------------------------------------------------------------
// tb_stencil_out_stream
// Scoreboard bench: the driver keeps its own raster position, pushes each
// kept beat's expected {data, eol, last} into a queue when accepted, and the
// queue head is compared whenever the DUT hands a beat downstream.
// Build with STENCIL_OUT_PERF_EN defined to also exercise stall_cycles.
// -----------------------------------------------------------------------------
module tb_stencil_out_stream;

    localparam int W     = 16;
    localparam int IW    = 64;
    localparam int IH    = 64;
    localparam int CMIN  = 4;
    localparam int RMIN  = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = IW * IH;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_eol;
    logic          out_last;
    logic          out_ready;
`ifdef STENCIL_OUT_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    stencil_out_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef STENCIL_OUT_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int             col_m = 0;
    int             row_m = 0;
    logic [W+1:0]   exp_q [$];

    // per-run statistics
    int out_cnt;
    int acc_cnt;
    int first_val;
    int first_eol;
    int last_cnt;
    int last_val;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        out_cnt   = 0;
        acc_cnt   = 0;
        first_val = -1;
        first_eol = -1;
        last_cnt  = 0;
        last_val  = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data",  32'(out_data),  32'd0);
        check_val("rst_out_eol",   32'(out_eol),   32'd0);
        check_val("rst_out_last",  32'(out_last),  32'd0);
        check_val("rst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b0;
        exp_q.delete();
        col_m = 0;
        row_m = 0;
        clear_stats();
    endtask

    // One clock: drive inputs at negedge, then check the combinational view
    // that the next posedge will sample, and update the model accordingly.
    task automatic cycle(input logic v, input logic rdy);
        logic         keep_m;
        logic [W+1:0] hd;
        @(negedge clk);
        in_valid  = v;
        in_data   = v ? W'(row_m * IW + col_m) : W'($urandom);
        out_ready = rdy;
        #1;
        keep_m = (col_m >= CMIN) && (row_m >= RMIN);
        check_val("in_ready",  32'(in_ready),  32'(!((exp_q.size() == DEPTH) && keep_m)));
        check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() == 0) begin
            check_val("out_empty_zero", 32'({out_data, out_eol, out_last}), 32'd0);
        end else if (rdy) begin
            hd = exp_q.pop_front();
            check_val("out_beat", 32'({out_data, out_eol, out_last}), 32'(hd));
            $display("beat %0d data=%0d eol=%0b last=%0b", out_cnt, out_data, out_eol, out_last);
            if (out_cnt == 0) first_val = int'(out_data);
            if (out_eol && first_eol < 0) first_eol = int'(out_data);
            if (out_last) begin
                last_cnt++;
                last_val = int'(out_data);
            end
            out_cnt++;
        end
        if (v && in_ready) begin
            if (keep_m) begin
                exp_q.push_back({W'(row_m * IW + col_m), (col_m == IW - 1),
                                 (col_m == IW - 1) && (row_m == IH - 1)});
            end
            acc_cnt++;
            if (col_m == IW - 1) begin
                col_m = 0;
                row_m = (row_m == IH - 1) ? 0 : row_m + 1;
            end else begin
                col_m = col_m + 1;
            end
        end
    endtask

    // vmode 0: in_valid every cycle, 1: one cycle in three
    // rmode 0: out_ready always, 1: random out_ready
    task automatic run_frame(input int vmode, input int rmode);
        int   budget;
        logic v;
        logic r;
        budget = 0;
        while ((acc_cnt < FRAME || exp_q.size() != 0) && budget < 30000) begin
            v = (acc_cnt < FRAME) && (vmode == 0 || (budget % 3) == 0);
            r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(v, r);
            budget++;
        end
        if (budget >= 30000) check_val("frame_timeout", 32'd1, 32'd0);
    endtask

    task automatic fill_until_full();
        int budget;
        budget = 0;
        while (exp_q.size() < DEPTH && budget < 1000) begin
            cycle(1'b1, 1'b0);
            budget++;
        end
        if (budget >= 1000) check_val("fill_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int budget;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // 1: plain ramp frame with free-flowing output
        apply_reset();
        run_frame(0, 0);
        check_val("t1_out_count", 32'(out_cnt),   32'd3600);
        check_val("t1_first",     32'(first_val), 32'd260);
        check_val("t1_first_eol", 32'(first_eol), 32'd319);
        check_val("t1_last_cnt",  32'(last_cnt),  32'd1);
        check_val("t1_last_val",  32'(last_val),  32'd4095);

        // 2: output blocked from row 4, FIFO fills, only kept beats stall
        apply_reset();
        fill_until_full();
        repeat (10) cycle(1'b1, 1'b0);
        // 3: pop while full; space appears only on the following cycle
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        run_frame(0, 1);
        check_val("t2_out_count", 32'(out_cnt),  32'd3600);
        check_val("t2_last_cnt",  32'(last_cnt), 32'd1);
        check_val("t2_last_val",  32'(last_val), 32'd4095);

        // 4: sparse input, one beat in three
        apply_reset();
        run_frame(1, 0);
        check_val("t4_out_count", 32'(out_cnt),   32'd3600);
        check_val("t4_first",     32'(first_val), 32'd260);
        check_val("t4_last_cnt",  32'(last_cnt),  32'd1);

        // 5: reset mid-frame with three beats buffered
        apply_reset();
        budget = 0;
        while (!(row_m == 20 && col_m == 7) && budget < 5000) begin
            cycle(1'b1, 1'b1);
            budget++;
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            cycle(1'b0, 1'b1);
            budget++;
        end
        repeat (3) cycle(1'b1, 1'b0);
        check_val("t5_buffered", 32'(out_valid), 32'd1);
        apply_reset();
        run_frame(0, 1);
        check_val("t5_first",     32'(first_val), 32'd260);
        check_val("t5_out_count", 32'(out_cnt),   32'd3600);
        check_val("t5_last_cnt",  32'(last_cnt),  32'd1);

`ifdef STENCIL_OUT_PERF_EN
        // 6: stall counter over exactly 100 blocked kept beats
        apply_reset();
        check_val("t6_stall_rst", stall_cycles, 32'd0);
        fill_until_full();
        repeat (100) cycle(1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_val("t6_stall_cycles", stall_cycles, 32'd100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
